// File: rtl/dac_stream_player.sv
// Burst player: pops a programmed number of words from the FIFO and drives them to the DAC.
// Optional macro DAC_PLAYER_TRIG_EN adds a trig input and an ARM state that waits for it.
module dac_stream_player #(
  parameter int bus_width = 256,
  parameter int len_width = 16
) (
  input  logic                 axis_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [len_width-1:0] num_words,
  input  logic [bus_width-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [bus_width-1:0] dac_tdata,
  output logic                 dac_tvalid,
  output logic                 busy,
  output logic                 done,
  output logic                 underflow
`ifdef DAC_PLAYER_TRIG_EN
  ,
  input  logic                 trig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [len_width-1:0] cnt_q, cnt_d;
  logic [bus_width-1:0] dac_tdata_q, dac_tdata_d;
  logic                 dac_tvalid_q, dac_tvalid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 underflow_q, underflow_d;
  logic                 pop;

  // The FIFO is popped only while playing; every other state holds it off.
  assign pop = (state_q == S_PLAY) && s_axis_tvalid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    underflow_d  = underflow_q;
    dac_tdata_d  = '0;
    dac_tvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d       = num_words;
          underflow_d = 1'b0;
          if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef DAC_PLAYER_TRIG_EN
            state_d = S_ARM;
`else
            state_d = S_PLAY;
`endif
          end
        end
      end
`ifdef DAC_PLAYER_TRIG_EN
      S_ARM: begin
        if (trig) state_d = S_PLAY;
      end
`endif
      S_PLAY: begin
        if (pop) begin
          dac_tdata_d  = s_axis_tdata;
          dac_tvalid_d = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - len_width'(1);
          if (cnt_q <= len_width'(1)) state_d = S_DONE;
        end else begin
          // Starved mid-burst: emit a zero gap and keep waiting for data.
          underflow_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dac_tdata_q  <= '0;
      dac_tvalid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dac_tdata_q  <= dac_tdata_d;
      dac_tvalid_q <= dac_tvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign s_axis_tready = (state_q == S_PLAY);
  assign dac_tdata     = dac_tdata_q;
  assign dac_tvalid    = dac_tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_dac_stream_player.sv
// Bench for dac_stream_player: FIFO emulation, per-cycle behavioural model, directed bursts.
module tb_dac_stream_player;
  localparam int BW = 256;
  localparam int LW = 16;
`ifdef DAC_PLAYER_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_words = '0;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [BW-1:0] dac_tdata;
  logic          dac_tvalid, busy, done, underflow;
  logic          trig = 1'b0;

  always #5 clk = ~clk;

  // FIFO emulation: a word array with read/write pointers; stall forces tvalid low.
  logic [BW-1:0] mem [0:63];
  int rd = 0, wr = 0;
  logic stall = 1'b0;
  assign s_axis_tvalid = (rd < wr) && !stall;
  assign s_axis_tdata  = (rd < wr) ? mem[rd % 64] : '0;

  dac_stream_player #(.bus_width(BW), .len_width(LW)) dut (
    .axis_clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .dac_tdata(dac_tdata), .dac_tvalid(dac_tvalid), .busy(busy), .done(done),
    .underflow(underflow)
`ifdef DAC_PLAYER_TRIG_EN
    , .trig(trig)
`endif
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase of the burst and words still owed.
  localparam int M_IDLE = 0, M_ARM = 1, M_PLAY = 2, M_FIN = 3;
  int            m_mode = M_IDLE;
  int            m_left = 0;
  logic [BW-1:0] e_data = '0;
  logic          e_vld = 0, e_uf = 0, e_busy = 0, e_done = 0;
  int            cyc = 0;

  logic [BW-1:0] obs[$];
  int            obs_edge[$];
  int            done_cnt = 0, done_edge = -1, tr_hi = 0;

  always @(posedge clk) begin
    bit pop;
    pop = 0;
    cyc++;
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; e_data = '0; e_vld = 0; e_uf = 0;
    end else begin
      e_data = '0; e_vld = 0;
      if (m_mode == M_IDLE) begin
        if (start) begin
          m_left = int'(num_words);
          e_uf   = 0;
          if (m_left == 0) m_mode = M_FIN;
          else m_mode = TRIG_EN ? M_ARM : M_PLAY;
        end
      end else if (m_mode == M_ARM) begin
        if (trig) m_mode = M_PLAY;
      end else if (m_mode == M_PLAY) begin
        if (s_axis_tvalid) begin
          pop = 1; e_data = s_axis_tdata; e_vld = 1; m_left--;
          if (m_left == 0) m_mode = M_FIN;
        end else begin
          e_uf = 1;
        end
      end else begin
        m_mode = M_IDLE;
      end
    end
    e_busy = (m_mode != M_IDLE);
    e_done = (m_mode == M_FIN);
    #1;
    if (pop) rd++;
    check("dac_tdata", dac_tdata, e_data);
    check("dac_tvalid", BW'(dac_tvalid), BW'(e_vld));
    check("busy", BW'(busy), BW'(e_busy));
    check("done", BW'(done), BW'(e_done));
    check("underflow", BW'(underflow), BW'(e_uf));
    check("tready", BW'(s_axis_tready), BW'(m_mode == M_PLAY));
    if (dac_tvalid) begin obs.push_back(dac_tdata); obs_edge.push_back(cyc); end
    if (done) begin done_cnt++; done_edge = cyc; end
    if (s_axis_tready) tr_hi++;
  end

  task automatic push_word(input logic [BW-1:0] v);
    mem[wr % 64] = v;
    wr++;
  endtask

  task automatic clear_obs();
    obs.delete(); obs_edge.delete(); done_cnt = 0; done_edge = -1; tr_hi = 0;
  endtask

  // Returns the index of the clock edge that samples the start pulse.
  task automatic do_start(input int n, output int s);
    @(negedge clk);
    start = 1'b1; num_words = LW'(n); s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 60) begin @(negedge clk); k++; end
    if (k >= 60) begin
      total++; bad++;
      $display("FAIL %s timeout busy=%b required=0", name, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    int s, t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dac_tdata", dac_tdata, '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_tready", BW'(s_axis_tready), '0);

    // Four words with tvalid held high: back-to-back output, one done pulse.
    clear_obs();
    for (int i = 1; i <= 4; i++) push_word(BW'(i));
    do_start(4, s);
    wait_idle("A_idle");
    check("A_count", BW'(obs.size()), BW'(4));
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check("A_word", obs[i], BW'(i + 1));
      check("A_edge", BW'(obs_edge[i]), BW'(s + 1 + i));
    end
    check("A_done_cnt", BW'(done_cnt), BW'(1));
    check("A_done_edge", BW'(done_edge), BW'(s + 4));
    check("A_busy_after", BW'(busy), '0);

    // Three words with a two-cycle starvation after the first.
    clear_obs();
    push_word(BW'(32'h11)); push_word(BW'(32'h22)); push_word(BW'(32'h33));
    do_start(3, s);
    @(negedge clk); stall = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b0;
    wait_idle("B_idle");
    check("B_count", BW'(obs.size()), BW'(3));
    if (obs.size() == 3) begin
      check("B_w1", obs[0], BW'(32'h11));
      check("B_w2", obs[1], BW'(32'h22));
      check("B_w3", obs[2], BW'(32'h33));
      check("B_gap", BW'(obs_edge[1] - obs_edge[0]), BW'(3));
    end
    check("B_done_edge", BW'(done_edge), BW'(s + 5));
    check("B_underflow_sticky", BW'(underflow), BW'(1));

    // Zero-length burst: immediate done, FIFO never popped.
    clear_obs();
    do_start(0, s);
    wait_idle("C_idle");
    check("C_done_edge", BW'(done_edge), BW'(s));
    check("C_done_cnt", BW'(done_cnt), BW'(1));
    check("C_tready_hi", BW'(tr_hi), '0);
    check("C_underflow_clr", BW'(underflow), '0);

    // Start pulse mid-burst must be ignored.
    clear_obs();
    push_word(BW'(32'hA1)); push_word(BW'(32'hA2)); push_word(BW'(32'hA3));
    stall = 1'b1;
    do_start(3, s);
    @(negedge clk);
    stall = 1'b0; start = 1'b1; num_words = LW'(9);
    @(negedge clk);
    start = 1'b0;
    wait_idle("D_idle");
    check("D_count", BW'(obs.size()), BW'(3));
    if (obs.size() == 3) check("D_w3", obs[2], BW'(32'hA3));
    check("D_done_cnt", BW'(done_cnt), BW'(1));
    check("D_done_edge", BW'(done_edge), BW'(s + 4));
    check("D_underflow", BW'(underflow), BW'(1));

    // Reset held three cycles mid-burst; unconsumed FIFO words survive.
    clear_obs();
    for (int i = 1; i <= 5; i++) push_word(BW'(32'hE0 + i));
    do_start(5, s);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("E_rst_dac", dac_tdata, '0);
    check("E_rst_vld", BW'(dac_tvalid), '0);
    check("E_rst_busy", BW'(busy), '0);
    check("E_rst_uf", BW'(underflow), '0);
    check("E_consumed", BW'(obs.size()), BW'(1));
    clear_obs();
    do_start(4, s);
    wait_idle("E_idle");
    check("E_count", BW'(obs.size()), BW'(4));
    if (obs.size() == 4) begin
      check("E_first", obs[0], BW'(32'hE2));
      check("E_last", obs[3], BW'(32'hE5));
    end
    check("E_done_cnt", BW'(done_cnt), BW'(1));

`ifdef DAC_PLAYER_TRIG_EN
    // Armed burst waits for a delayed trigger.
    clear_obs();
    push_word(BW'(32'hF1)); push_word(BW'(32'hF2));
    do_start(2, s);
    repeat (10) @(negedge clk);
    check("F_tready_armed", BW'(tr_hi), '0);
    check("F_busy_armed", BW'(busy), BW'(1));
    trig = 1'b1; t = cyc + 1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle("F_idle");
    check("F_count", BW'(obs.size()), BW'(2));
    if (obs.size() == 2) check("F_first_edge", BW'(obs_edge[0]), BW'(t + 1));
`else
    t = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
